// File: rtl/im_fetch_unit_if.sv
// Instruction fetch bus: the IM read port plus the (instruction, pc) stream to decode.
// Ports: im_addr/im_cs/im_we/im_oe/im_data (IM read port),
//        out_valid/out_ready/out_instr/out_pc (decode handshake).
// master = fetch unit, slave = instruction memory + decode stage.
interface im_fetch_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] im_addr;
  logic                  im_cs;
  logic                  im_we;
  logic                  im_oe;
  logic [DATA_WIDTH-1:0] im_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    output im_addr, im_cs, im_we, im_oe,
    input  im_data,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  im_addr, im_cs, im_we, im_oe,
    output im_data,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/im_fetch_unit.sv
// Instruction fetch: PC + IM read port + prefetch FIFO feeding decode, with branch redirect.
// Latency: 1 cycle from an IM read to the entry at the FIFO head; 1 instr/cycle sustained.
// Backpressure: out_ready low fills the FIFO, then IM reads stop until a pop frees a slot.
// Ports: clk, rst_n (async active-low), start (IDLE->FETCH pulse), redirect/redirect_pc
//        (flush + PC reload), halted (registered), bus (im_fetch_unit_if.master).
// Optional: define FETCH_HALT_DETECT_EN to stop fetching after a HALT_OPCODE instruction.
module im_fetch_unit #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  halted,
  im_fetch_unit_if.master       bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  entry_t                fifo [FIFO_DEPTH];
  entry_t                head;

  logic                  fire;
  logic                  pop;
  logic                  handshake;

  assign head      = fifo[rd_ptr];
  assign handshake = bus.out_valid & bus.out_ready;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign fire      = (state == FETCH) & ~redirect &
                     ((count < CNT_W'(FIFO_DEPTH)) | handshake);
  // A pop coinciding with a redirect is discarded along with the flushed entries.
  assign pop       = handshake & ~redirect;

  assign bus.im_addr   = pc;
  assign bus.im_cs     = fire;
  assign bus.im_oe     = fire;
  assign bus.im_we     = 1'b0;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = bus.out_valid ? head.instr : '0;
  assign bus.out_pc    = bus.out_valid ? head.pc    : '0;

`ifdef FETCH_HALT_DETECT_EN
  logic halt_push;
  logic halted_q;
  assign halt_push = fire & (bus.im_data == HALT_OPCODE);
  assign halted    = halted_q;
`else
  assign halted    = 1'b0;
`endif

  // Control FSM; halted is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
`ifdef FETCH_HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
`ifdef FETCH_HALT_DETECT_EN
          if (halt_push) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end
`endif
        end
        HALTED: begin
          if (redirect) begin
            state    <= FETCH;
`ifdef FETCH_HALT_DETECT_EN
            halted_q <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // PC, pointers and occupancy. Redirect overrides any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      pc     <= redirect_pc;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (fire) begin
        pc     <= pc + ADDR_WIDTH'(1);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fire, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (fire) fifo[wr_ptr] <= '{instr: bus.im_data, pc: pc};
  end

endmodule

// File: tb/tb_im_fetch_unit.sv
// Testbench for im_fetch_unit: directed stimulus with a scoreboard queue of expected
// (pc, instr) pairs drained by an independent monitor on each accepted handshake.
module tb_im_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       halted;

  int checks = 0;
  int errors = 0;
  int pushes;

  logic [7:0] imem [256];

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] pc;
  } exp_t;
  exp_t exp_q[$];

  im_fetch_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  im_fetch_unit #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .FIFO_DEPTH(4), .RESET_PC(8'h00), .HALT_OPCODE(8'hFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .halted(halted),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Asynchronous-read instruction memory model.
  always_comb bus.im_data = imem[bus.im_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_entry(input logic [7:0] pc, input logic [7:0] instr);
    exp_q.push_back('{instr: instr, pc: pc});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n         = 1'b0;
    start         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 8'h00;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_im_cs", {31'b0, bus.im_cs}, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted (non-redirected) handshake must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc %0h instr %0h, required no entry",
                   bus.out_pc, bus.out_instr);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", {24'b0, bus.out_pc}, {24'b0, e.pc});
          check("pop_instr", {24'b0, bus.out_instr}, {24'b0, e.instr});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'(i + 10);
    bus.out_ready = 1'b0;

    // 1: reset values and idle without start
    #2;
    check("reset_im_cs", {31'b0, bus.im_cs}, 32'd0);
    check("reset_im_oe", {31'b0, bus.im_oe}, 32'd0);
    check("reset_im_we", {31'b0, bus.im_we}, 32'd0);
    check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset_halted", {31'b0, halted}, 32'd0);
    check("reset_out_instr", {24'b0, bus.out_instr}, 32'd0);
    check("reset_out_pc", {24'b0, bus.out_pc}, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    repeat (5) tick;
    @(negedge clk);
    check("idle_im_cs", {31'b0, bus.im_cs}, 32'd0);
    check("idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("idle_halted", {31'b0, halted}, 32'd0);
    check("idle_im_addr", {24'b0, bus.im_addr}, 32'd0);
    tick;

    // 2: streaming, pcs 0..5 on consecutive cycles
    for (int i = 0; i < 6; i++) expect_entry(8'(i), 8'(10 + i));
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    @(negedge clk);
    check("stream_first_cycle_valid", {31'b0, bus.out_valid}, 32'd0);
    tick;
    repeat (6) begin
      @(negedge clk);
      check("stream_valid", {31'b0, bus.out_valid}, 32'd1);
      tick;
    end
    bus.out_ready = 1'b0;
    check("stream_drained", exp_q.size(), 32'd0);

    // 3: backpressure
    apply_reset;
    start = 1'b1;
    tick;
    start = 1'b0;
    pushes = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.im_cs) pushes++;
      tick;
    end
    check("bp_pushes", pushes, 32'd4);
    @(negedge clk);
    check("bp_full_im_cs", {31'b0, bus.im_cs}, 32'd0);
    check("bp_full_pc", {24'b0, bus.im_addr}, 32'd4);
    check("bp_head_pc", {24'b0, bus.out_pc}, 32'd0);
    check("bp_head_instr", {24'b0, bus.out_instr}, 32'd10);
    tick;
    expect_entry(8'h00, 8'd10);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_push_im_cs", {31'b0, bus.im_cs}, 32'd1);
    tick;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_after_pc", {24'b0, bus.im_addr}, 32'd5);
    check("bp_after_still_full", {31'b0, bus.im_cs}, 32'd0);
    check("bp_after_head_pc", {24'b0, bus.out_pc}, 32'd1);
    check("bp_drained", exp_q.size(), 32'd0);
    tick;

    // 4: redirect with 3 entries buffered and a pop offered the same cycle
    apply_reset;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    redirect      = 1'b1;
    redirect_pc   = 8'h40;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("redir_pre_valid", {31'b0, bus.out_valid}, 32'd1);
    check("redir_no_fetch", {31'b0, bus.im_cs}, 32'd0);
    tick;
    redirect = 1'b0;
    expect_entry(8'h40, 8'h4A);
    expect_entry(8'h41, 8'h4B);
    @(negedge clk);
    check("redir_flush_valid", {31'b0, bus.out_valid}, 32'd0);
    check("redir_im_addr", {24'b0, bus.im_addr}, 32'h40);
    check("redir_resume_cs", {31'b0, bus.im_cs}, 32'd1);
    tick;
    tick;
    tick;
    bus.out_ready = 1'b0;
    check("redir_drained", exp_q.size(), 32'd0);

    // 5: PC wrap, starting from a redirect taken in IDLE
    apply_reset;
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    tick;
    redirect = 1'b0;
    @(negedge clk);
    check("idle_redir_addr", {24'b0, bus.im_addr}, 32'hFE);
    check("idle_redir_no_fetch", {31'b0, bus.im_cs}, 32'd0);
    tick;
    expect_entry(8'hFE, 8'h08);
    expect_entry(8'hFF, 8'h09);
    expect_entry(8'h00, 8'h0A);
    expect_entry(8'h01, 8'h0B);
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    repeat (4) begin
      @(negedge clk);
      tick;
    end
    bus.out_ready = 1'b0;
    check("wrap_drained", exp_q.size(), 32'd0);

    // 6: HALT opcode at address 3
    imem[3] = 8'hFF;
    apply_reset;
    expect_entry(8'h00, 8'd10);
    expect_entry(8'h01, 8'd11);
    expect_entry(8'h02, 8'd12);
    expect_entry(8'h03, 8'hFF);
`ifndef FETCH_HALT_DETECT_EN
    expect_entry(8'h04, 8'd14);
    expect_entry(8'h05, 8'd15);
`endif
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    pushes = 0;
    repeat (7) begin
      @(negedge clk);
      if (bus.im_cs) pushes++;
      tick;
    end
    bus.out_ready = 1'b0;
    check("halt_drained", exp_q.size(), 32'd0);
    @(negedge clk);
`ifdef FETCH_HALT_DETECT_EN
    check("halt_pushes", pushes, 32'd4);
    check("halt_halted", {31'b0, halted}, 32'd1);
    check("halt_pc", {24'b0, bus.im_addr}, 32'd4);
    check("halt_no_fetch", {31'b0, bus.im_cs}, 32'd0);
    tick;
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    @(negedge clk);
    check("halt_redir_no_fetch", {31'b0, bus.im_cs}, 32'd0);
    tick;
    redirect = 1'b0;
    bus.out_ready = 1'b1;
    expect_entry(8'h10, 8'h1A);
    expect_entry(8'h11, 8'h1B);
    @(negedge clk);
    check("unhalt_halted", {31'b0, halted}, 32'd0);
    check("unhalt_im_cs", {31'b0, bus.im_cs}, 32'd1);
    check("unhalt_im_addr", {24'b0, bus.im_addr}, 32'h10);
    tick;
    tick;
    tick;
    bus.out_ready = 1'b0;
    check("unhalt_drained", exp_q.size(), 32'd0);
`else
    check("nohalt_pushes", pushes, 32'd7);
    check("nohalt_halted", {31'b0, halted}, 32'd0);
    check("nohalt_pc", {24'b0, bus.im_addr}, 32'd7);
    check("nohalt_fetching", {31'b0, bus.im_cs}, 32'd1);
`endif
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
